decode_buffer: RTL
==================

# decode_buffer

Parametrised decode-to-execute pipeline buffer. It replaces the single stall-gated decode output register with a DEPTH-entry elastic queue that uses a valid/ready handshake. Each entry holds one decoded instruction: PC, prediction bit, register indices, operand values, immediate, CSR field and an opaque control bundle. While an entry is queued, it snoops the writeback port and refreshes its stored operand values. It sits between the decode logic and register-file read on one side and the execute stage on the other.

## Interface
Parameters:
- XLEN, 64, data/PC/immediate width
- REG_AW, 9, register index width
- CSR_W, 24, CSR field width
- CTRL_W, 32, opaque decoded-control bundle width (alu/mem/csr/branch/rd_write fields, packed by decode)
- DEPTH, 2, queue entries, ≥1

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush_in  in  1  discard all queued and incoming entries
- in_valid  in  1  decode offers an entry
- in_ready  out  1  buffer accepts; equals count < DEPTH
- in_pc  in  XLEN
- in_pred_taken  in  1
- in_rs1, in_rs2, in_rd  in  REG_AW
- in_rs1_value, in_rs2_value  in  XLEN  register-file read data
- in_imm  in  XLEN
- in_csr  in  CSR_W
- in_ctrl  in  CTRL_W
- wb_write  in  1, wb_rd  in  REG_AW, wb_value  in  XLEN  writeback port
- out_valid  out  1  head entry present
- out_ready  in  1  execute consumes head
- out_pc, out_pred_taken, out_rs1, out_rs2, out_rd, out_rs1_value, out_rs2_value, out_imm, out_csr, out_ctrl  out  widths as inputs  head entry fields
- count_out  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Enqueue: in_valid && in_ready && !flush_in. The entry is written at wr_ptr, wr_ptr advances, and the entry becomes visible next cycle.
- Dequeue: out_valid && out_ready. rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0, so DEPTH need not be a power of two. count_out is incremented and decremented independently, so simultaneous enqueue and dequeue leaves it unchanged.
- Enqueue capture bypass: if wb_write && wb_rd == in_rs1 && in_rs1 != 0, store wb_value instead of in_rs1_value. The same rule applies to rs2.
- Register index 0 never matches a writeback.
- Flush: count → 0, pointers → 0, out_valid → 0 next cycle. Any enqueue in the same cycle is dropped. A dequeue handshake in the flush cycle is still considered taken by execute, but that is execute's concern; the buffer simply empties.
- Output fields show the head entry whenever out_valid=1. When empty, fields hold the last written head slot contents, and the consumer must ignore them.

## Timing
- Reset (rst_n=0 at edge): count_out=0, out_valid=0, in_ready=1, all out_* data fields 0, pointers 0, all entry storage 0.
- Latency is 1 cycle from enqueue to out_valid. There is no same-cycle pass-through.
- in_ready depends only on registered count, with no combinational path from out_ready. A full queue with out_ready=1 reopens in_ready the next cycle.
- out_valid = (count_out != 0), registered.
- Snoop updates (see Configuration) are visible on out_* the cycle after the writeback. The writeback value in the same cycle is not reflected on out_*; execute forwards that case itself.
- Precedence: rst_n > flush_in > enqueue/dequeue/snoop.

## Configuration
- DECODE_BUFFER_SNOOP_EN defined: every cycle, each valid entry with stored rs1 (rs2) == wb_rd, wb_write=1, and index ≠ 0 has its stored rs1_value (rs2_value) overwritten with wb_value. Both operands of one entry may update in the same cycle.
- Undefined: stored values are frozen at enqueue, apart from the capture bypass. Hazard stalling upstream must cover queued entries, and no per-entry comparators are built.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, count_out=0, in_ready=1, out_pc=0.
- Fill and drain, DEPTH=2, out_ready=0: enqueue pc=0x100 and then pc=0x104 → in_ready=0 after 2 enqueues. Then set out_ready=1 → out_pc 0x100 then 0x104, count_out 2→1→0.
- Simultaneous traffic: count=1, enqueue and dequeue every cycle for 8 cycles → count_out stays 1 and the PCs emerge in order, including across pointer wrap.
- Flush with enqueue: count=2, flush_in=1 with in_valid=1 → next cycle count_out=0, out_valid=0, and the incoming entry never appears.
- Capture bypass: in_rs1=5, in_rs1_value=0x11, wb_write=1, wb_rd=5, wb_value=0x22 → out_rs1_value=0x22. Repeat with rs1=0 and wb_rd=0 → stored value is in_rs1_value.
- Snoop (SNOOP_EN): entry with rs2=7 queued and out_ready=0; wb_rd=7, wb_value=0xDEAD → out_rs2_value=0xDEAD next cycle. With the macro undefined, the original value is retained.

Source files
------------

// File: rtl/decode_buffer.sv
// decode_buffer: DEPTH-entry elastic decode-to-execute queue with writeback capture bypass.
// Define DECODE_BUFFER_SNOOP_EN to also refresh queued operand values from the writeback port.
module decode_buffer #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 9,
   parameter int CSR_W  = 24,
   parameter int CTRL_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            in_pc,
   input  logic                       in_pred_taken,
   input  logic [REG_AW-1:0]          in_rs1,
   input  logic [REG_AW-1:0]          in_rs2,
   input  logic [REG_AW-1:0]          in_rd,
   input  logic [XLEN-1:0]            in_rs1_value,
   input  logic [XLEN-1:0]            in_rs2_value,
   input  logic [XLEN-1:0]            in_imm,
   input  logic [CSR_W-1:0]           in_csr,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic                       wb_write,
   input  logic [REG_AW-1:0]          wb_rd,
   input  logic [XLEN-1:0]            wb_value,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic                       out_pred_taken,
   output logic [REG_AW-1:0]          out_rs1,
   output logic [REG_AW-1:0]          out_rs2,
   output logic [REG_AW-1:0]          out_rd,
   output logic [XLEN-1:0]            out_rs1_value,
   output logic [XLEN-1:0]            out_rs2_value,
   output logic [XLEN-1:0]            out_imm,
   output logic [CSR_W-1:0]           out_csr,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [$clog2(DEPTH+1)-1:0] count_out
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [XLEN-1:0]   pc_q   [DEPTH];
   logic              pred_q [DEPTH];
   logic [REG_AW-1:0] rs1_q  [DEPTH];
   logic [REG_AW-1:0] rs2_q  [DEPTH];
   logic [REG_AW-1:0] rd_q   [DEPTH];
   logic [XLEN-1:0]   v1_q   [DEPTH];
   logic [XLEN-1:0]   v2_q   [DEPTH];
   logic [XLEN-1:0]   imm_q  [DEPTH];
   logic [CSR_W-1:0]  csr_q  [DEPTH];
   logic [CTRL_W-1:0] ctrl_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              enq, deq;
   logic [XLEN-1:0]   rs1_cap, rs2_cap;
   assign in_ready  = count_q < CW'(DEPTH);
   assign out_valid = count_q != '0;
   assign count_out = count_q;
   assign enq = in_valid && in_ready && !flush_in;
   assign deq = out_valid && out_ready;
   // A writeback landing in the enqueue cycle would otherwise be lost to this entry
   assign rs1_cap = (wb_write && wb_rd == in_rs1 && in_rs1 != '0) ? wb_value : in_rs1_value;
   assign rs2_cap = (wb_write && wb_rd == in_rs2 && in_rs2 != '0) ? wb_value : in_rs2_value;
   always_comb begin
      wr_ptr_d = flush_in ? '0 : !enq ? wr_ptr_q : wr_ptr_q == PW'(DEPTH-1) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = flush_in ? '0 : !deq ? rd_ptr_q : rd_ptr_q == PW'(DEPTH-1) ? '0 : rd_ptr_q + 1'b1;
      count_d  = flush_in ? '0 : count_q + CW'(enq) - CW'(deq);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
`ifdef DECODE_BUFFER_SNOOP_EN
   logic [DEPTH-1:0] vld_q;
   always_ff @(posedge clk) begin
      if (!rst_n || flush_in) begin
         vld_q <= '0;
      end else begin
         if (deq) vld_q[rd_ptr_q] <= 1'b0;
         if (enq) vld_q[wr_ptr_q] <= 1'b1;
      end
   end
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            pred_q[i] <= 1'b0;
            rs1_q[i]  <= '0;
            rs2_q[i]  <= '0;
            rd_q[i]   <= '0;
            v1_q[i]   <= '0;
            v2_q[i]   <= '0;
            imm_q[i]  <= '0;
            csr_q[i]  <= '0;
            ctrl_q[i] <= '0;
         end
      end else begin
`ifdef DECODE_BUFFER_SNOOP_EN
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && wb_write && wb_rd != '0 && rs1_q[i] == wb_rd) v1_q[i] <= wb_value;
            if (vld_q[i] && wb_write && wb_rd != '0 && rs2_q[i] == wb_rd) v2_q[i] <= wb_value;
         end
`endif
         if (enq) begin
            pc_q[wr_ptr_q]   <= in_pc;
            pred_q[wr_ptr_q] <= in_pred_taken;
            rs1_q[wr_ptr_q]  <= in_rs1;
            rs2_q[wr_ptr_q]  <= in_rs2;
            rd_q[wr_ptr_q]   <= in_rd;
            v1_q[wr_ptr_q]   <= rs1_cap;
            v2_q[wr_ptr_q]   <= rs2_cap;
            imm_q[wr_ptr_q]  <= in_imm;
            csr_q[wr_ptr_q]  <= in_csr;
            ctrl_q[wr_ptr_q] <= in_ctrl;
         end
      end
   end
   assign out_pc         = pc_q[rd_ptr_q];
   assign out_pred_taken = pred_q[rd_ptr_q];
   assign out_rs1        = rs1_q[rd_ptr_q];
   assign out_rs2        = rs2_q[rd_ptr_q];
   assign out_rd         = rd_q[rd_ptr_q];
   assign out_rs1_value  = v1_q[rd_ptr_q];
   assign out_rs2_value  = v2_q[rd_ptr_q];
   assign out_imm        = imm_q[rd_ptr_q];
   assign out_csr        = csr_q[rd_ptr_q];
   assign out_ctrl       = ctrl_q[rd_ptr_q];
endmodule
